// File: rtl/reverse_pkg.sv
// Shared constants for the reverse bit-permutation unit: mode encodings and
// the default operand width.
package reverse_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_FULL = 2'b01;
  localparam logic [1:0] MODE_NIB  = 2'b10;
  localparam logic [1:0] MODE_HALF = 2'b11;

  localparam int NIBBLE_BITS = 4;

  // A width is usable only if it splits into whole nibbles and halves.
  function automatic bit width_is_legal(input int width);
    return (width >= NIBBLE_BITS) && ((width % NIBBLE_BITS) == 0);
  endfunction

endpackage : reverse_pkg

// File: rtl/reverse_core.sv
// Combinational permutation network: builds the full, per-nibble and
// half-swapped views of the operand and selects one by mode.
module reverse_core
  import reverse_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] result
);

  localparam int HALF     = WIDTH / 2;
  localparam int NIBBLES  = WIDTH / NIBBLE_BITS;

  logic [WIDTH-1:0] full_rev;
  logic [WIDTH-1:0] nib_rev;
  logic [WIDTH-1:0] half_swap;

  for (genvar i = 0; i < WIDTH; i++) begin : g_full
    assign full_rev[i] = a[WIDTH-1-i];
  end

  for (genvar k = 0; k < NIBBLES; k++) begin : g_nib
    for (genvar j = 0; j < NIBBLE_BITS; j++) begin : g_bit
      assign nib_rev[NIBBLE_BITS*k + j] = a[NIBBLE_BITS*k + (NIBBLE_BITS-1) - j];
    end
  end

  for (genvar h = 0; h < HALF; h++) begin : g_half
    assign half_swap[h + HALF] = a[h];
    assign half_swap[h]        = a[h + HALF];
  end

  always_comb begin
    // NOTE: assign a default before the case so no path leaves result
    // unassigned; otherwise synthesis infers a latch.
    result = a;
    case (mode)
      MODE_PASS: result = a;
      MODE_FULL: result = full_rev;
      MODE_NIB:  result = nib_rev;
      MODE_HALF: result = half_swap;
      default:   result = a;
    endcase
  end

endmodule : reverse_core

// File: rtl/reverse.sv
// Registered bit-permutation unit (pass / full / nibble / half swap), one-cycle
// latency, valid-qualified. Define REVERSE_PARITY_EN to add the y_par output.
module reverse
  import reverse_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  output logic             out_valid,
  output logic [WIDTH-1:0] y
`ifdef REVERSE_PARITY_EN
  ,
  output logic             y_par
`endif
);

  if (!width_is_legal(WIDTH)) begin : g_bad_width
    $error("reverse: WIDTH must be a multiple of 4 and >= 4");
  end

  logic [WIDTH-1:0] result;

  reverse_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a      (a),
    .mode   (mode),
    .result (result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples pre-edge values, independent of statement order.
      out_valid <= in_valid;
    end
  end

  // y only loads on accepted operands; idle cycles keep the last result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y <= '0;
    end else if (in_valid) begin
      y <= result;
    end
  end

`ifdef REVERSE_PARITY_EN
  // Parity is registered with y under the same enable so the two never diverge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_par <= 1'b0;
    end else if (in_valid) begin
      y_par <= ^result;
    end
  end
`endif

endmodule : reverse

// File: tb/tb_reverse.sv
// Self-checking bench for reverse: scoreboard of expected results, literal
// vectors, streaming, hold, asynchronous reset and involution checks.
module tb_reverse;
  import reverse_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [1:0]   mode;
  logic [W-1:0] a;
  logic         out_valid;
  logic [W-1:0] y;
`ifdef REVERSE_PARITY_EN
  logic         y_par;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] sb[$];
  logic [W-1:0] last_y;

  always #5 clk = ~clk;

  reverse #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .mode      (mode),
    .a         (a),
    .out_valid (out_valid),
    .y         (y)
`ifdef REVERSE_PARITY_EN
    ,
    .y_par     (y_par)
`endif
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Reference written with streaming operators rather than bit loops.
  function automatic logic [W-1:0] model(input logic [1:0] m, input logic [W-1:0] v);
    logic [W-1:0] r;
    r = {<<{v}};
    case (m)
      2'b00:   return v;
      2'b01:   return r;
      2'b10:   return {<<4{r}};
      default: return {v[W/2-1:0], v[W-1:W/2]};
    endcase
  endfunction

  // One cycle: drive at negedge, sample 1 time unit after the rising edge.
  task automatic step(input string tag, input logic v, input logic [1:0] m,
                      input logic [W-1:0] av, input logic [W-1:0] exp_y);
    logic [W-1:0] e;
    @(negedge clk);
    in_valid = v;
    mode     = m;
    a        = av;
    if (v) sb.push_back(exp_y);
    @(posedge clk);
    #1;
    check({tag, ".valid"}, {7'd0, out_valid}, {7'd0, v});
    if (v) begin
      e = sb.pop_front();
      check(tag, y, e);
      last_y = e;
    end else begin
      check({tag, ".hold"}, y, last_y);
    end
`ifdef REVERSE_PARITY_EN
    check({tag, ".par"}, {7'd0, y_par}, {7'd0, ^last_y});
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] rv;
    logic [W-1:0] mid;
    logic [1:0]   rm;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    mode     = MODE_PASS;
    a        = '0;
    last_y   = '0;
    #12;
    check("reset.y", y, 8'h00);
    check("reset.valid", {7'd0, out_valid}, 8'h00);

    // Release with in_valid low: nothing updates on the release edge.
    @(negedge clk);
    rst_n = 1'b1;
    step("release", 1'b0, MODE_FULL, 8'hFF, 8'h00);

    step("0f.full", 1'b1, MODE_FULL, 8'b00001111, 8'b11110000);
    step("0f.nib",  1'b1, MODE_NIB,  8'b00001111, 8'b00001111);
    step("0f.half", 1'b1, MODE_HALF, 8'b00001111, 8'b11110000);
    step("0f.pass", 1'b1, MODE_PASS, 8'b00001111, 8'b00001111);
    step("b1.full", 1'b1, MODE_FULL, 8'b10110001, 8'b10001101);
    step("b1.nib",  1'b1, MODE_NIB,  8'b10110001, 8'b11011000);
    step("b1.half", 1'b1, MODE_HALF, 8'b10110001, 8'b00011011);

`ifdef REVERSE_PARITY_EN
    step("par.b1", 1'b1, MODE_FULL, 8'b10110001, 8'b10001101);
    check("par.b1.lit", {7'd0, y_par}, 8'h00);
    step("par.07", 1'b1, MODE_FULL, 8'h07, 8'hE0);
    check("par.07.lit", {7'd0, y_par}, 8'h01);
`endif

    // Back-to-back stream, one operand per cycle.
    step("stream0", 1'b1, MODE_FULL, 8'h01, 8'h80);
    step("stream1", 1'b1, MODE_FULL, 8'h80, 8'h01);
    step("stream2", 1'b1, MODE_FULL, 8'h3C, 8'h3C);

    // Hold: mode and operand changes while idle must not reach y.
    step("pre_hold", 1'b1, MODE_FULL, 8'h01, 8'h80);
    step("hold0", 1'b0, MODE_PASS, 8'hFF, 8'h00);
    step("hold1", 1'b0, MODE_NIB,  8'h5A, 8'h00);
    check("hold.lit", y, 8'h80);

    // Random vectors plus the involution property for the three permutations.
    for (int i = 0; i < 24; i++) begin
      rv = W'($urandom);
      rm = 2'($urandom_range(0, 3));
      step("rand", 1'b1, rm, rv, model(rm, rv));
      if (rm != MODE_PASS) begin
        mid = y;
        step("invol", 1'b1, rm, mid, rv);
      end
    end

    // Asynchronous reset mid-stream, checked before any further clock edge.
    step("pre_rst", 1'b1, MODE_PASS, 8'hA5, 8'hA5);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst.y", y, 8'h00);
    check("async_rst.valid", {7'd0, out_valid}, 8'h00);
`ifdef REVERSE_PARITY_EN
    check("async_rst.par", {7'd0, y_par}, 8'h00);
`endif
    // Reset dominates in_valid.
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("rst_dom.y", y, 8'h00);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    last_y   = '0;
    step("post_rst", 1'b0, MODE_FULL, 8'h3C, 8'h00);
    step("post_rst.run", 1'b1, MODE_NIB, 8'h3C, 8'hC3);

    check("sb.empty", W'(sb.size()), 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_reverse
